ps2_key_event_queue: RTL
========================

Name: ps2_key_event_queue

Overview:
- Sits between kbd_protocol and scancode_decoder (and make_pwm) on the clkdiv4 domain.
- Turns the raw PS/2 byte stream (scancode + flag) into complete key events: make or break, normal or extended (E0).
- Optionally suppresses typematic repeats, and buffers events in a first-word-fall-through (FWFT) FIFO with a valid/ready handshake, so slow consumers never lose keystrokes.

Parameters:
DEPTH, 8, FIFO entries; power of 2, minimum 2.
AW, 3, log2(DEPTH).
SUPPRESS_REPEAT, 1, 1 = drop repeated make of a key already held.
TIMEOUT, 4095, cycles a prefix state may wait for its next byte before aborting to IDLE.

Ports:
clk  input  1  system clock (clkdiv4 at top).
reset  input  1  synchronous, active-high reset.
flag  input  1  byte-ready from kbd_protocol; level, may stay high many cycles.
scancode  input  8  received byte; valid when flag rises.
ev_ready  input  1  consumer accepts head event this cycle.
clr_ovf  input  1  clears overflow.
ev_valid  output  1  FIFO non-empty.
ev_code  output  8  head event scancode (prefix bytes stripped).
ev_break  output  1  head event is key release.
ev_ext  output  1  head event carried E0 prefix.
count  output  AW+1  FIFO occupancy, 0..DEPTH.
overflow  output  1  sticky; an event was dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, priority over everything):
  - FIFO empty; outputs ev_valid, ev_code, ev_break, ev_ext and count all 0 (head data forced to 0 while empty).
  - overflow=0, decoder in IDLE, held-key register invalid, timeout counter 0, flag_d=0.
- Byte strobe:
  - flag_d is flag registered.
  - strobe = flag & ~flag_d; exactly one byte per rising edge of flag.
  - A flag held high is consumed once.
- Decoder FSM, advances only on strobe (b = scancode):
  - IDLE:
    - b=E0 -> EXT.
    - b=F0 -> BRK.
    - b=00, FF, E1 or AA -> discard, stay IDLE.
    - Otherwise emit {ext=0, brk=0, b}.
  - EXT:
    - b=F0 -> EXTBRK.
    - b=E0 -> stay EXT.
    - Otherwise emit {1, 0, b} -> IDLE.
  - BRK:
    - b=F0 -> stay BRK.
    - b=E0 -> EXTBRK (tolerated reorder).
    - Otherwise emit {0, 1, b} -> IDLE.
  - EXTBRK:
    - b=E0 or F0 -> stay.
    - Otherwise emit {1, 1, b} -> IDLE.
  - In EXT, BRK and EXTBRK, the byte values 00 and FF -> discard and go to IDLE.
- Timeout:
  - The counter clears on every strobe and counts up while in EXT, BRK or EXTBRK.
  - When it reaches TIMEOUT -> IDLE with no emit.
- Repeat filter (SUPPRESS_REPEAT=1):
  - held = {valid, ext, code}.
  - A make event matching a valid held entry is dropped (not counted as overflow).
  - Any other make event is emitted and loads held.
  - A break event matching held is emitted and invalidates held.
  - A non-matching break event is emitted and leaves held unchanged.
  - With SUPPRESS_REPEAT=0, every event is emitted and held is unused.
- FIFO:
  - An emitted event is written at the end of the strobe cycle; ev_valid is high the next cycle.
  - Latency: rising flag edge sampled at cycle k -> event at head in cycle k+1 (if the FIFO was empty).
  - Pop occurs when ev_valid & ev_ready; the head advances next cycle.
  - ev_ready while empty is ignored.
  - Push while full without a pop: event dropped, overflow set to 1.
  - Push and pop in the same cycle while full: both happen, count stays DEPTH, no overflow.
  - Push and pop in the same cycle while count=1: the new event becomes the head next cycle, count stays 1.
  - Pointers are AW bits and wrap modulo DEPTH; count is tracked separately, range 0..DEPTH.
- Overflow register:
  - overflow holds until clr_ovf.
  - clr_ovf and a new drop in the same cycle -> overflow stays 1 (set wins).
- Reset mid-sequence (for example after E0 F0): sequence abandoned and FIFO flushed; the next byte is decoded from IDLE.

Test Plan:
1. Bytes 1C, then F0 1C, with ev_ready=1 -> events {code=1C, brk=0, ext=0} then {1C, brk=1, ext=0}; count returns to 0. Each event appears one cycle after its flag rise.
2. Bytes E0 75, E0 F0 75 -> {75, ext=1, brk=0}, then {75, ext=1, brk=1}. Holding flag high 20 cycles on one byte yields a single event.
3. SUPPRESS_REPEAT=1, bytes 1C 1C 1C F0 1C 1C -> exactly three events: make 1C, break 1C, make 1C. With SUPPRESS_REPEAT=0 the same stream gives five events.
4. ev_ready=0, DEPTH=8, send 10 distinct make codes -> count=8, overflow=1, the FIFO holds the first 8 in order. Then ev_ready=1 while a ninth strobe arrives -> count stays 8, no extra drop. clr_ovf -> overflow=0.
5. Send E0, then idle TIMEOUT+2 cycles, then 1C -> single event {1C, ext=0}. Send F0, then assert reset for 1 cycle, then 1C -> {1C, brk=0}, and the queue holds only that event.
6. Bytes 00, AA, FF, E1 -> no events, count=0, overflow=0.

Source files
------------

// File: rtl/ps2_key_event_queue_if.sv
// Key-event stream from ps2_key_event_queue to its consumer.
// The head event is presented while ev_valid is high and is taken when ev_ready is high.
interface ps2_key_event_queue_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ev_ext;

  modport master (output ev_valid, ev_code, ev_break, ev_ext, input ev_ready);
  modport slave  (input ev_valid, ev_code, ev_break, ev_ext, output ev_ready);
endinterface

// File: rtl/ps2_key_event_queue.sv
// Assembles PS/2 bytes into make/break (optionally E0-extended) key events and queues them in a FWFT FIFO.
// Event reaches the head one cycle after the flag rise; when full and not popping, new events are dropped and overflow sets.
module ps2_key_event_queue #(
  parameter int DEPTH           = 8,
  parameter int AW              = 3,
  parameter int SUPPRESS_REPEAT = 1,
  parameter int TIMEOUT         = 4095
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flag,
  input  logic [7:0]            scancode,
  input  logic                  clr_ovf,
  output logic [AW:0]           count,
  output logic                  overflow,
  ps2_key_event_queue_if.master ev
);

  localparam int             TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TMAX     = TIMEOUT[TW-1:0];
  localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK} state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_ev_t;

  state_t        state, state_nx;
  logic          flag_d;
  logic          strobe;
  logic [TW-1:0] tcnt;
  logic          timed_out;
  logic          is_pfx, is_nul;

  logic          dec_vld;
  key_ev_t       dec_ev;

  logic          held_vld;
  logic          held_ext;
  logic [7:0]    held_code;
  logic          held_match;
  logic          emit;

  key_ev_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, push_ok, drop;
  key_ev_t       head;

  assign strobe    = flag & ~flag_d;
  assign timed_out = (state != S_IDLE) && (tcnt == TMAX);
  assign is_pfx    = (scancode == 8'hE0) || (scancode == 8'hF0);
  assign is_nul    = (scancode == 8'h00) || (scancode == 8'hFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      flag_d <= 1'b0;
      tcnt   <= '0;
    end else begin
      state  <= state_nx;
      flag_d <= flag;
      if (strobe || state == S_IDLE || timed_out)
        tcnt <= '0;
      else
        tcnt <= tcnt + TW'(1);
    end
  end

  // A byte arriving in the same cycle as the timeout wins over the abort.
  always_comb begin
    state_nx = state;
    if (strobe) begin
      case (state)
        S_IDLE:   if (scancode == 8'hE0)      state_nx = S_EXT;
                  else if (scancode == 8'hF0) state_nx = S_BRK;
        S_EXT:    if (scancode == 8'hF0)      state_nx = S_EXTBRK;
                  else if (scancode != 8'hE0) state_nx = S_IDLE;
        S_BRK:    if (scancode == 8'hE0)      state_nx = S_EXTBRK;
                  else if (scancode != 8'hF0) state_nx = S_IDLE;
        S_EXTBRK: if (!is_pfx)                state_nx = S_IDLE;
        default:  state_nx = S_IDLE;
      endcase
    end else if (timed_out) begin
      state_nx = S_IDLE;
    end
  end

  always_comb begin
    dec_vld     = 1'b0;
    dec_ev.ext  = (state == S_EXT) || (state == S_EXTBRK);
    dec_ev.brk  = (state == S_BRK) || (state == S_EXTBRK);
    dec_ev.code = scancode;
    if (strobe) begin
      if (state == S_IDLE)
        dec_vld = !(is_pfx || is_nul || scancode == 8'hE1 || scancode == 8'hAA);
      else
        dec_vld = !(is_pfx || is_nul);
    end
  end

  assign held_match = held_vld && (held_ext == dec_ev.ext) && (held_code == dec_ev.code);
  assign emit       = dec_vld && !((SUPPRESS_REPEAT != 0) && !dec_ev.brk && held_match);

  always_ff @(posedge clk) begin
    if (reset) begin
      held_vld  <= 1'b0;
      held_ext  <= 1'b0;
      held_code <= 8'h00;
    end else if ((SUPPRESS_REPEAT != 0) && dec_vld) begin
      if (!dec_ev.brk && !held_match) begin
        held_vld  <= 1'b1;
        held_ext  <= dec_ev.ext;
        held_code <= dec_ev.code;
      end else if (dec_ev.brk && held_match) begin
        held_vld  <= 1'b0;
      end
    end
  end

  // A pop frees the slot the simultaneous push needs, so a full queue still accepts.
  assign full    = (count == FULL_CNT);
  assign pop     = (count != '0) && ev.ev_ready;
  assign push_ok = emit && (!full || pop);
  assign drop    = emit && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= dec_ev;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  assign head        = mem[rd_ptr];
  assign ev.ev_valid = (count != '0);
  assign ev.ev_code  = ev.ev_valid ? head.code : 8'h00;
  assign ev.ev_break = ev.ev_valid & head.brk;
  assign ev.ev_ext   = ev.ev_valid & head.ext;

endmodule
